// File: rtl/hilo_mdu.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, plus direct MTHI/MTLO moves into the HI/LO registers.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q, quo_q, rem_q, dvsr_q, a_q;
  logic               neg_q, rneg_q, div0_q;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic               signed_d, a_neg_d, b_neg_d, last_d, div_ok_d;
  logic [WIDTH-1:0]   mag_a_d, mag_b_d, div_rem_d, div_quo_d;
  logic [2*WIDTH-1:0] mul_sum_d;
  logic [WIDTH:0]     div_sh_d;

  always_comb begin
    signed_d  = (op == OP_MULT) || (op == OP_DIV);
    a_neg_d   = signed_d & srca[WIDTH-1];
    b_neg_d   = signed_d & srcb[WIDTH-1];
    mag_a_d   = cneg(srca, a_neg_d);
    mag_b_d   = cneg(srcb, b_neg_d);
    last_d    = (cnt_q == CW'(WIDTH-1));
    mul_sum_d = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    // Partial remainder stays below the divisor, so the shifted value needs one extra bit.
    div_sh_d  = {rem_q, quo_q[WIDTH-1]};
    div_ok_d  = (div_sh_d >= {1'b0, dvsr_q});
    div_rem_d = div_ok_d ? WIDTH'(div_sh_d - {1'b0, dvsr_q}) : div_sh_d[WIDTH-1:0];
    div_quo_d = {quo_q[WIDTH-2:0], div_ok_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                prod_q   <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, mag_a_d};
                mplier_q <= mag_b_d;
                neg_q    <= a_neg_d ^ b_neg_d;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                rem_q    <= '0;
                quo_q    <= mag_a_d;
                dvsr_q   <= mag_b_d;
                a_q      <= srca;
                neg_q    <= a_neg_d ^ b_neg_d;
                rneg_q   <= a_neg_d;
                div0_q   <= (srcb == '0);
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= S_DIV;
              end
              OP_MTHI: hi_q <= srca;
              OP_MTLO: lo_q <= srca;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            prod_q   <= mul_sum_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_d) begin
              {hi_q, lo_q} <= cneg2(mul_sum_d, neg_q);
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            rem_q <= div_rem_d;
            quo_q <= div_quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_d) begin
              // Divide by zero reports the raw dividend rather than the magnitude remainder.
              if (div0_q) begin
                hi_q <= a_q;
                lo_q <= '1;
              end else begin
                hi_q <= cneg(div_rem_d, rneg_q);
                lo_q <= cneg(div_quo_d, neg_q);
              end
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed corner cases followed by random
// operations compared against a 64-bit arithmetic reference model.
module tb_hilo_mdu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] srca = '0;
  logic [W-1:0] srcb = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  hilo_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd1: begin u = sa * sb; hi_m = u[63:32]; lo_m = u[31:0]; end
      3'd2: begin u = {32'b0, a} * {32'b0, b}; hi_m = u[63:32]; lo_m = u[31:0]; end
      3'd3, 3'd4: begin
        if (b == '0) begin
          hi_m = a;
          lo_m = '1;
        end else if (o == 3'd3) begin
          q = sa / sb;
          r = sa % sb;
          u = q; lo_m = u[31:0];
          u = r; hi_m = u[31:0];
        end else begin
          lo_m = a / b;
          hi_m = a % b;
        end
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit start_in_done);
    int n;
    logic [W-1:0] hi_s, lo_s;
    op = o; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("busy_rise", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_len", 64'(n), 64'(W));
    chk("done_pulse", done, 1);
    model(o, a, b);
    chk("hi", hi, hi_m);
    chk("lo", lo, lo_m);
    hi_s = hi; lo_s = lo;
    if (start_in_done) begin
      op = 3'd2; srca = 32'd7; srcb = 32'd7; start = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    chk("done_clear", done, 0);
    if (start_in_done) begin
      chk("done_start_ignored", busy, 0);
      chk("done_start_hi", hi, hi_s);
      chk("done_start_lo", lo, lo_s);
    end
  endtask

  task automatic mv(input logic [2:0] o, input logic [W-1:0] a);
    op = o; srca = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    model(o, a, '0);
    chk("mv_busy", busy, 0);
    chk("mv_done", done, 0);
    chk("mv_hi", hi, hi_m);
    chk("mv_lo", lo, lo_m);
  endtask

  initial begin
    int n, pulses;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    mv(3'd5, 32'h1234);

    // MULTU 2*3 with MTLO requests held during busy
    op = 3'd2; srca = 32'd2; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    op = 3'd6; srca = 32'hDEADBEEF;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0; op = 3'd0;
    n = 3;
    while (busy === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("mtlo_busy_len", 64'(n), 64'(W));
    chk("mtlo_done", done, 1);
    model(3'd2, 32'd2, 32'd3);
    chk("mtlo_ignored_lo", lo, 32'd6);
    chk("mtlo_hi", hi, hi_m);
    @(posedge clk); #1;

    issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    chk("mult_neg_hi", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo", lo, 32'hFFFFFFF1);
    issue(3'd4, 32'd100, 32'd7, 1'b0);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    chk("ovf_lo", lo, 32'h80000000);
    issue(3'd4, 32'd9, 32'd0, 1'b0);
    issue(3'd3, 32'hFFFFFFF7, 32'd0, 1'b0);
    issue(3'd3, 32'd7, 32'hFFFFFFFE, 1'b0);

    // Flush at busy cycle 10
    op = 3'd2; srca = 32'hFFFF; srcb = 32'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_pre_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, hi_m);
    chk("flush_lo", lo, lo_m);
    pulses = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    chk("flush_no_done", 64'(pulses), 0);

    // Flush together with start in IDLE discards the request
    op = 3'd5; srca = 32'hCAFE; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    op = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; op = 3'd0;
    chk("flush_start_busy", busy, 0);
    chk("flush_start_hi", hi, hi_m);

    // Asynchronous reset in the middle of a divide
    op = 3'd3; srca = 32'd1000; srcb = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    hi_m = '0; lo_m = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(3'd4, 32'd10, 32'd3, 1'b0);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd1);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        3: ra = 32'h80000000;
        default: ;
      endcase
      if (ro <= 3'd4) issue(ro, ra, rb, 1'b0);
      else mv(ro, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and HI/LO register width (8 to 64, even).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, request strobe sampled each rising clk edge.
REQ-005 SHALL have port op, input, 3 bits, operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000/111 no-op.
REQ-006 SHALL have ports srca and srcb, input, WIDTH bits each, operands: rs and rt, or the move source on srca.
REQ-007 SHALL have port flush, input, 1 bit, pipeline flush that cancels the in-flight operation.
REQ-008 SHALL have port busy, output, 1 bit, iterative operation in progress; the pipeline uses it as a stall.
REQ-009 SHALL have port done, output, 1 bit, one-cycle pulse after HI/LO commit from MULT/MULTU/DIV/DIVU.
REQ-010 SHALL have ports hi and lo, output, WIDTH bits each, current HI/LO register contents driven straight from flops.

Function
REQ-011 SHALL implement a state machine with states IDLE, MUL, DIV and DONE.
REQ-012 In IDLE, start=1 with MULT/MULTU SHALL latch the operands and go to MUL; with DIV/DIVU SHALL latch the operands and go to DIV; start is edge-sampled.
REQ-013 SHALL raise busy starting in the cycle after the accepting edge and hold it for exactly WIDTH cycles in MUL or DIV.
REQ-014 MUL SHALL perform a radix-2 shift-add on operand magnitudes, one bit per cycle, WIDTH iterations.
REQ-015 For signed MUL, the product SHALL be negated when the operand signs differ, giving a 2*WIDTH two's-complement result; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-016 DIV SHALL perform restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations; LO = quotient, HI = remainder.
REQ-017 For signed DIV, the quotient SHALL be negative when the operand signs differ, and the remainder SHALL take the sign of the dividend (truncating division).
REQ-018 For divide by zero (srcb=0): HI = dividend, LO = all ones; same latency as any other divide.
REQ-019 For signed overflow (most-negative / -1): LO = most-negative, HI = 0.
REQ-020 On the edge ending the WIDTH-th iteration: HI and LO SHALL update, busy SHALL fall, and the FSM SHALL enter DONE, giving done=1 for exactly one cycle.
REQ-021 DONE SHALL return to IDLE unconditionally; start in DONE SHALL be ignored (busy=0 there, so the pipeline does not issue into it).
REQ-022 MTHI/MTLO with start in IDLE SHALL write srca into HI/LO on the sampling edge, with no busy and no done, and remain in IDLE.
REQ-023 start while busy SHALL be ignored; the operation, HI and LO SHALL be unaffected.
REQ-024 flush=1 in MUL or DIV SHALL abort to IDLE on that edge: HI/LO unchanged, busy=0 next cycle, no done pulse.
REQ-025 flush and start in the same IDLE cycle: flush SHALL win and the request SHALL be discarded.
REQ-026 flush in IDLE or DONE SHALL have no effect on HI/LO.
REQ-027 Iteration count and intermediate results SHALL be sized for any WIDTH; no 32-bit constants.

Reset
REQ-028 rst low SHALL force, asynchronously: FSM to IDLE, hi=0, lo=0, busy=0, done=0, and clear the iteration counter and partial results.
REQ-029 Reset mid-operation SHALL discard the operation; after release, the first accepted start SHALL behave as from cold.

Verification (WIDTH=32)
REQ-030 MULT srca=0xFFFFFFFD (-3), srcb=5 -> busy high for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
REQ-031 DIVU 100/7 -> lo=14, hi=2 after 32 cycles; DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 9/0 -> hi=9, lo=0xFFFFFFFF.
REQ-033 MTHI 0x1234 with hi previously 0 -> hi=0x1234 the next cycle with busy never asserted; then MULTU 2*3 and MTLO asserted during busy -> the MTLO is ignored, and lo=6 at completion.
REQ-034 MULTU started, flush at busy cycle 10 -> busy=0 the next cycle, hi/lo keep prior values, no done pulse.
REQ-035 rst low asynchronously at DIV cycle 5 -> outputs zero immediately; after release, DIVU 10/3 -> lo=3, hi=1.
